// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter sharing one i2c_basic master between
// NUM_REQ requesters. The winning slot's transaction is latched into m_*,
// a one-cycle m_start is issued, and the winner gets a one-cycle req_done
// once i2c_basic reports done.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN
//   defined   - TIMEOUT_BITS-wide watchdog aborts a stuck transaction and
//               pulses req_err together with req_done for the winner.
//   undefined - no watchdog, req_err is held at zero, BUSY waits forever.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no owner; arbitrate and latch the winner's transaction
// START    | m_start pulse to i2c_basic
// WAIT_LOW | wait for m_done to be low (ignore a stale level done)
// BUSY     | transaction in flight, wait for m_done
// DONE     | req_done pulse to winner, advance round-robin pointer

module i2c_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [2*NUM_REQ-1:0]   req_num_bytes,
    input  logic [24*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    output logic [NUM_REQ-1:0]     grant,
    output logic [6:0]             m_addr,
    output logic [1:0]             m_num_bytes,
    output logic [7:0]             m_wr_data0,
    output logic [7:0]             m_wr_data1,
    output logic [7:0]             m_wr_data2,
    output logic                   m_start,
    input  logic                   m_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT_LOW = 3'd2,
        S_BUSY     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] pick;
    logic             pick_valid;
    logic [IDX_W:0]   scan_idx;
    logic [IDX_W:0]   win_inc;
    logic [IDX_W-1:0] rr_nxt;
    logic [1:0]       pick_nb;

`ifdef I2C_ARB_TIMEOUT_EN
    // Abort is decided one count early so DONE coincides with the counter
    // reaching all-ones.
    localparam logic [TIMEOUT_BITS-1:0] TO_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    logic [TIMEOUT_BITS-1:0] to_cnt;
    logic                    to_hit;
    logic                    to_abort;
    logic                    timed_out;

    assign to_hit   = (to_cnt == TO_LAST);
    assign to_abort = to_hit && ((state == S_WAIT_LOW) || ((state == S_BUSY) && !m_done));
`endif

    // Round-robin search: first set req bit starting at rr_ptr, wrapping.
    always_comb begin
        pick       = rr_ptr;
        pick_valid = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!pick_valid && req[scan_idx[IDX_W-1:0]]) begin
                pick       = scan_idx[IDX_W-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    // Pointer advance past the winner, and zero-byte requests promoted to one.
    always_comb begin
        win_inc = {1'b0, winner} + (IDX_W+1)'(1);
        rr_nxt  = (win_inc >= NREQ) ? '0 : win_inc[IDX_W-1:0];
        pick_nb = req_num_bytes[2*int'(pick) +: 2];
        if (pick_nb == 2'd0) begin
            pick_nb = 2'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
`ifdef I2C_ARB_TIMEOUT_EN
                if (to_hit) begin
                    state_nxt = S_DONE;
                end else if (!m_done) begin
                    state_nxt = S_BUSY;
                end
`else
                if (!m_done) begin
                    state_nxt = S_BUSY;
                end
`endif
            end
            S_BUSY: begin
`ifdef I2C_ARB_TIMEOUT_EN
                if (m_done || to_hit) begin
                    state_nxt = S_DONE;
                end
`else
                if (m_done) begin
                    state_nxt = S_DONE;
                end
`endif
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the winner's transaction in IDLE; advance the pointer in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_addr      <= '0;
            m_num_bytes <= '0;
            m_wr_data0  <= '0;
            m_wr_data1  <= '0;
            m_wr_data2  <= '0;
            winner      <= '0;
            rr_ptr      <= '0;
        end else begin
            if ((state == S_IDLE) && pick_valid) begin
                m_addr      <= req_addr[7*int'(pick) +: 7];
                m_num_bytes <= pick_nb;
                m_wr_data0  <= req_data[24*int'(pick)      +: 8];
                m_wr_data1  <= req_data[24*int'(pick) + 8  +: 8];
                m_wr_data2  <= req_data[24*int'(pick) + 16 +: 8];
                winner      <= pick;
            end
            if (state == S_DONE) begin
                rr_ptr <= rr_nxt;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: cleared on the way into START, counts while waiting on i2c_basic.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt    <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state_nxt == S_START) begin
                to_cnt    <= '0;
                timed_out <= 1'b0;
            end else if ((state == S_WAIT_LOW) || (state == S_BUSY)) begin
                to_cnt    <= to_cnt + 1'b1;
                timed_out <= to_abort;
            end
        end
    end
`endif

    // Outputs decoded from state and the latched winner.
    always_comb begin
        m_start  = (state == S_START);
        grant    = '0;
        req_done = '0;
        req_err  = '0;
        if ((state == S_START) || (state == S_WAIT_LOW) || (state == S_BUSY)) begin
            grant[winner] = 1'b1;
        end
        if (state == S_DONE) begin
            req_done[winner] = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
            req_err[winner]  = timed_out;
`endif
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed-step bench for i2c_arbiter with NUM_REQ=2.
// With I2C_ARB_TIMEOUT_EN defined the DUT gets a 4-bit watchdog and the
// timeout scenario is exercised as well.

module tb_i2c_arbiter;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TB_TO_BITS = 4;
`else
    localparam int TB_TO_BITS = 20;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [13:0] req_addr;
    logic [3:0]  req_num_bytes;
    logic [47:0] req_data;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic [1:0]  grant;
    logic [6:0]  m_addr;
    logic [1:0]  m_num_bytes;
    logic [7:0]  m_wr_data0;
    logic [7:0]  m_wr_data1;
    logic [7:0]  m_wr_data2;
    logic        m_start;
    logic        m_done;

    int n_cmp  = 0;
    int n_fail = 0;

    i2c_arbiter #(.NUM_REQ(2), .TIMEOUT_BITS(TB_TO_BITS)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_addr      (req_addr),
        .req_num_bytes (req_num_bytes),
        .req_data      (req_data),
        .req_done      (req_done),
        .req_err       (req_err),
        .grant         (grant),
        .m_addr        (m_addr),
        .m_num_bytes   (m_num_bytes),
        .m_wr_data0    (m_wr_data0),
        .m_wr_data1    (m_wr_data1),
        .m_wr_data2    (m_wr_data2),
        .m_start       (m_start),
        .m_done        (m_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while ((m_start !== 1'b1) && (k < 8)) begin
            tick();
            k++;
        end
        check(tag, 32'(m_start), 32'h1);
    endtask

    // One full transaction with a single-cycle m_done pulse in BUSY.
    task automatic txn(input string tag, input logic [31:0] exp_grant,
                       input logic [31:0] exp_addr, input logic [31:0] exp_nb);
        wait_start({tag, "_start"});
        check({tag, "_grant"}, 32'(grant), exp_grant);
        check({tag, "_addr"}, 32'(m_addr), exp_addr);
        check({tag, "_nb"}, 32'(m_num_bytes), exp_nb);
        tick();
        tick();
        m_done = 1'b1;
        tick();
        check({tag, "_done"}, 32'(req_done), exp_grant);
        check({tag, "_err"}, 32'(req_err), 32'h0);
        m_done = 1'b0;
        tick();
        check({tag, "_done_clr"}, 32'(req_done), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench timed out");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset         = 1'b1;
        req           = 2'b00;
        req_addr      = '0;
        req_num_bytes = '0;
        req_data      = '0;
        m_done        = 1'b0;
        tick();
        tick();

        // reset state
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_start", 32'(m_start), 32'h0);
        check("rst_done", 32'(req_done), 32'h0);
        check("rst_addr", 32'(m_addr), 32'h0);
        check("rst_nb", 32'(m_num_bytes), 32'h0);
        reset = 1'b0;
        tick();

        // single req[0], addr 0x20, 3 bytes 06/00/00
        req_addr[6:0]      = 7'h20;
        req_num_bytes[1:0] = 2'd3;
        req_data[23:0]     = 24'h000006;
        req                = 2'b01;
        check("t1_start_early", 32'(m_start), 32'h0);
        tick();
        check("t1_start", 32'(m_start), 32'h1);
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_addr", 32'(m_addr), 32'h20);
        check("t1_nb", 32'(m_num_bytes), 32'h3);
        check("t1_d0", 32'(m_wr_data0), 32'h06);
        check("t1_d1", 32'(m_wr_data1), 32'h00);
        check("t1_d2", 32'(m_wr_data2), 32'h00);
        tick();
        check("t1_start_pulse", 32'(m_start), 32'h0);
        tick();
        m_done = 1'b1;
        tick();
        check("t1_done", 32'(req_done), 32'h1);
        check("t1_grant_clr", 32'(grant), 32'h0);
        m_done = 1'b0;
        req    = 2'b00;
        tick();
        check("t1_done_clr", 32'(req_done), 32'h0);
        check("t1_addr_hold", 32'(m_addr), 32'h20);
        tick();
        check("t1_no_regrant", 32'(grant), 32'h0);

        // req=11 held from reset: grants alternate 0,1,0,1; slot0 has 0 bytes -> 1
        reset              = 1'b1;
        req_addr           = {7'h22, 7'h11};
        req_num_bytes      = {2'd2, 2'd0};
        req_data           = {24'hCCBBAA, 24'h332211};
        req                = 2'b11;
        tick();
        reset = 1'b0;
        txn("rr0", 32'h1, 32'h11, 32'h1);
        txn("rr1", 32'h2, 32'h22, 32'h2);
        txn("rr2", 32'h1, 32'h11, 32'h1);
        txn("rr3", 32'h2, 32'h22, 32'h2);
        req = 2'b00;
        tick();
        check("rr_idle", 32'(grant), 32'h0);

        // req[1] dropped mid-BUSY: completes, req_done[1] pulses, no regrant
        req = 2'b10;
        wait_start("drop_start");
        check("drop_d0", 32'(m_wr_data0), 32'hAA);
        check("drop_d2", 32'(m_wr_data2), 32'hCC);
        tick();
        tick();
        req = 2'b00;
        tick();
        m_done = 1'b1;
        tick();
        check("drop_done", 32'(req_done), 32'h2);
        m_done = 1'b0;
        tick();
        tick();
        tick();
        check("drop_no_grant", 32'(grant), 32'h0);
        check("drop_no_start", 32'(m_start), 32'h0);

        // stale m_done held high before start
        m_done = 1'b1;
        req    = 2'b01;
        tick();
        check("stale_start", 32'(m_start), 32'h1);
        tick();
        tick();
        tick();
        tick();
        check("stale_grant", 32'(grant), 32'h1);
        check("stale_no_done", 32'(req_done), 32'h0);
        m_done = 1'b0;
        tick();
        tick();
        check("stale_busy_no_done", 32'(req_done), 32'h0);
        m_done = 1'b1;
        tick();
        check("stale_done", 32'(req_done), 32'h1);
        req    = 2'b00;
        m_done = 1'b0;
        tick();

        // reset asserted in BUSY
        req = 2'b10;
        wait_start("rstb_start");
        tick();
        tick();
        check("rstb_grant", 32'(grant), 32'h2);
        reset  = 1'b1;
        m_done = 1'b1;
        tick();
        check("rstb_grant0", 32'(grant), 32'h0);
        check("rstb_start0", 32'(m_start), 32'h0);
        check("rstb_done0", 32'(req_done), 32'h0);
        check("rstb_addr0", 32'(m_addr), 32'h0);
        reset  = 1'b0;
        m_done = 1'b0;
        req    = 2'b00;
        tick();
        check("rstb_idle_done", 32'(req_done), 32'h0);
        check("rstb_idle_grant", 32'(grant), 32'h0);

        // rr pointer back at 0 after reset
        req = 2'b11;
        txn("post_rst", 32'h1, 32'h11, 32'h1);
        req = 2'b00;
        tick();

`ifdef I2C_ARB_TIMEOUT_EN
        // m_done never rises: abort 15 cycles after WAIT_LOW entry
        req = 2'b01;
        wait_start("to_start");
        tick();
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        check("to_early", 32'(req_done), 32'h0);
        tick();
        check("to_done", 32'(req_done), 32'h1);
        check("to_err", 32'(req_err), 32'h1);
        req = 2'b00;
        tick();
        check("to_err_clr", 32'(req_err), 32'h0);
        req = 2'b10;
        txn("to_next", 32'h2, 32'h22, 32'h2);
        req = 2'b00;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
